// File: rtl/paired_register_file.sv
// paired_register_file: split-half register file with step unit; PAIRED_REGFILE_BYPASS_EN forwards same-cycle updates to reads
module paired_register_file #(
    parameter int HALF = 8,
    parameter int REGS = 4,
    localparam int AW = $clog2(REGS),
    localparam int W = 2 * HALF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] wr_num,
    input  logic [1:0]    wr_mode,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_num1,
    input  logic [AW-1:0] rd_num2,
    input  logic [1:0]    rd_mode1,
    input  logic [1:0]    rd_mode2,
    output logic [W-1:0]  rd_data1,
    output logic [W-1:0]  rd_data2,
    output logic          rd_valid1,
    output logic          rd_valid2,
    input  logic          step_en,
    input  logic          step_dec,
    input  logic [AW-1:0] step_num
);
`ifdef PAIRED_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic [HALF-1:0] hi_q [REGS];
    logic [HALF-1:0] lo_q [REGS];
    logic [HALF-1:0] hi_d [REGS];
    logic [HALF-1:0] lo_d [REGS];
    logic [HALF-1:0] h1, l1, h2, l2;
    logic [W-1:0] data1_d, data2_d;
    logic live, coll;
    // live is low on the first edge after reset release so that edge's requests are dropped
    assign coll = step_en && wr_mode != 2'b00 && wr_num == step_num;
    always_comb begin
        for (int i = 0; i < REGS; i++) begin
            hi_d[i] = hi_q[i];
            lo_d[i] = lo_q[i];
            if (live && step_en && !coll && step_num == AW'(i))
                {hi_d[i], lo_d[i]} = step_dec ? {hi_q[i], lo_q[i]} - W'(1) : {hi_q[i], lo_q[i]} + W'(1);
            if (live && wr_num == AW'(i)) begin
                if (wr_mode[0]) lo_d[i] = wr_data[HALF-1:0];
                if (wr_mode[1]) hi_d[i] = wr_mode[0] ? wr_data[W-1:HALF] : wr_data[HALF-1:0];
            end
        end
    end
    assign h1 = BYP ? hi_d[rd_num1] : hi_q[rd_num1];
    assign l1 = BYP ? lo_d[rd_num1] : lo_q[rd_num1];
    assign h2 = BYP ? hi_d[rd_num2] : hi_q[rd_num2];
    assign l2 = BYP ? lo_d[rd_num2] : lo_q[rd_num2];
    always_comb begin
        data1_d = !live ? '0 : rd_mode1 == 2'b11 ? {h1, l1} : rd_mode1 == 2'b10 ? W'(h1) : rd_mode1 == 2'b01 ? W'(l1) : '0;
        data2_d = !live ? '0 : rd_mode2 == 2'b11 ? {h2, l2} : rd_mode2 == 2'b10 ? W'(h2) : rd_mode2 == 2'b01 ? W'(l2) : '0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REGS; i++) begin
                hi_q[i] <= '0;
                lo_q[i] <= '0;
            end
            live <= 1'b0;
            rd_data1 <= '0;
            rd_data2 <= '0;
            rd_valid1 <= 1'b0;
            rd_valid2 <= 1'b0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            live <= 1'b1;
            rd_data1 <= data1_d;
            rd_data2 <= data2_d;
            rd_valid1 <= live && rd_mode1 != 2'b00;
            rd_valid2 <= live && rd_mode2 != 2'b00;
        end
    end
endmodule

// File: tb/tb_paired_register_file.sv
// tb_paired_register_file: directed scoreboard bench for paired_register_file (HALF=8, REGS=4)
module tb_paired_register_file;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [1:0] wr_num = '0, rd_num1 = '0, rd_num2 = '0, step_num = '0;
    logic [1:0] wr_mode = '0, rd_mode1 = '0, rd_mode2 = '0;
    logic [15:0] wr_data = '0;
    logic step_en = 1'b0, step_dec = 1'b0;
    logic [15:0] rd_data1, rd_data2;
    logic rd_valid1, rd_valid2;
    typedef struct {
        logic [15:0] d1;
        logic        v1;
        logic [15:0] d2;
        logic        v2;
    } exp_t;
    exp_t sb[$];
    logic [15:0] m [4];
    int checks = 0;
    int errors = 0;
`ifdef PAIRED_REGFILE_BYPASS_EN
    bit byp = 1'b1;
`else
    bit byp = 1'b0;
`endif
    always #5 clk = ~clk;
    paired_register_file #(.HALF(8), .REGS(4)) dut (
        .clk(clk), .rst(rst),
        .wr_num(wr_num), .wr_mode(wr_mode), .wr_data(wr_data),
        .rd_num1(rd_num1), .rd_num2(rd_num2),
        .rd_mode1(rd_mode1), .rd_mode2(rd_mode2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .rd_valid1(rd_valid1), .rd_valid2(rd_valid2),
        .step_en(step_en), .step_dec(step_dec), .step_num(step_num)
    );
    function automatic logic [15:0] rexp(input int md, input logic [15:0] w);
        return md == 3 ? w : md == 2 ? {8'h00, w[15:8]} : md == 1 ? {8'h00, w[7:0]} : 16'h0000;
    endfunction
    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask
    // one clock of stimulus: model the update, push the expected read, then compare after the edge
    task automatic cyc(input string tag, input int wm, input int wn, input int wd, input int se, input int sd,
                       input int sn, input int rm1, input int rn1, input int rm2, input int rn2, input int ign = 0);
        logic [15:0] n [4];
        exp_t e;
        n = m;
        if (ign == 0) begin
            if (se != 0 && !(wm != 0 && wn == sn)) n[sn] = sd != 0 ? m[sn] - 16'd1 : m[sn] + 16'd1;
            if (wm[0]) n[wn][7:0] = wd[7:0];
            if (wm[1]) n[wn][15:8] = wm[0] ? wd[15:8] : wd[7:0];
        end
        e.d1 = ign != 0 ? 16'h0 : rexp(rm1, byp ? n[rn1] : m[rn1]);
        e.v1 = ign == 0 && rm1 != 0;
        e.d2 = ign != 0 ? 16'h0 : rexp(rm2, byp ? n[rn2] : m[rn2]);
        e.v2 = ign == 0 && rm2 != 0;
        sb.push_back(e);
        m = n;
        wr_mode = 2'(wm); wr_num = 2'(wn); wr_data = 16'(wd);
        step_en = 1'(se); step_dec = 1'(sd); step_num = 2'(sn);
        rd_mode1 = 2'(rm1); rd_num1 = 2'(rn1); rd_mode2 = 2'(rm2); rd_num2 = 2'(rn2);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".d1"}, rd_data1, e.d1);
        chk({tag, ".v1"}, 16'(rd_valid1), 16'(e.v1));
        chk({tag, ".d2"}, rd_data2, e.d2);
        chk({tag, ".v2"}, 16'(rd_valid2), 16'(e.v2));
    endtask
    initial begin
        for (int i = 0; i < 4; i++) m[i] = 16'h0;
        #2 rst = 1'b1;
        #1;
        chk("rst.d1", rd_data1, 16'h0);
        chk("rst.v1", 16'(rd_valid1), 16'h0);
        chk("rst.d2", rd_data2, 16'h0);
        chk("rst.v2", 16'(rd_valid2), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        cyc("release_ignored", 3, 2, 'hFFFF, 1, 0, 2, 3, 2, 3, 2, 1);
        cyc("wr_full_r2", 3, 2, 'hA55A, 0, 0, 0, 0, 0, 0, 0);
        cyc("rd_full_r2", 0, 0, 0, 0, 0, 0, 3, 2, 0, 0);
        cyc("valid_drop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("wr_hi_r1", 2, 1, 'h0034, 0, 0, 0, 0, 0, 0, 0);
        cyc("wr_lo_r1", 1, 1, 'h0012, 0, 0, 0, 0, 0, 0, 0);
        cyc("rd_halves_r1", 0, 0, 0, 0, 0, 0, 2, 1, 1, 1);
        cyc("rd_full_r1_r2", 0, 0, 0, 0, 0, 0, 3, 1, 3, 2);
        cyc("wr_r3_ones", 3, 3, 'hFFFF, 0, 0, 0, 0, 0, 0, 0);
        cyc("step_inc_wrap", 0, 0, 0, 1, 0, 3, 0, 0, 0, 0);
        cyc("rd_r3_zero_step_dec", 0, 0, 0, 1, 1, 3, 3, 3, 0, 0);
        cyc("rd_r3_ones", 0, 0, 0, 0, 0, 0, 3, 3, 3, 3);
        cyc("wr_r0_00ff", 3, 0, 'h00FF, 0, 0, 0, 0, 0, 0, 0);
        cyc("step_r0_carry", 0, 0, 0, 1, 0, 0, 3, 0, 2, 0);
        cyc("rd_r0_0100", 0, 0, 0, 0, 0, 0, 3, 0, 1, 0);
        cyc("collide_full", 3, 0, 'h1234, 1, 0, 0, 0, 0, 0, 0);
        cyc("rd_r0_1234", 0, 0, 0, 0, 0, 0, 3, 0, 0, 0);
        cyc("collide_lo", 1, 0, 'h00AB, 1, 1, 0, 0, 0, 0, 0);
        cyc("rd_r0_12ab", 0, 0, 0, 0, 0, 0, 3, 0, 2, 0);
        cyc("wr_r1_step_r2", 3, 1, 'h5678, 1, 0, 2, 0, 0, 0, 0);
        cyc("rd_r1_r2", 0, 0, 0, 0, 0, 0, 3, 1, 3, 2);
        cyc("wr_r1_1111", 3, 1, 'h1111, 0, 0, 0, 0, 0, 0, 0);
        cyc("wr_rd_same_r1", 3, 1, 'h2222, 0, 0, 0, 3, 1, 1, 1);
        cyc("rd_r1_2222", 0, 0, 0, 0, 0, 0, 3, 1, 2, 1);
        rd_mode1 = 2'd3; rd_num1 = 2'd2; rd_mode2 = 2'd3; rd_num2 = 2'd0;
        @(posedge clk);
        #1;
        chk("pre_rst.v1", 16'(rd_valid1), 16'h1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst.d1", rd_data1, 16'h0);
        chk("async_rst.v1", 16'(rd_valid1), 16'h0);
        chk("async_rst.v2", 16'(rd_valid2), 16'h0);
        @(posedge clk);
        #1;
        chk("in_rst.v1", 16'(rd_valid1), 16'h0);
        chk("in_rst.d2", rd_data2, 16'h0);
        for (int i = 0; i < 4; i++) m[i] = 16'h0;
        @(negedge clk);
        rst = 1'b0;
        cyc("release2_ignored", 3, 0, 'hBEEF, 0, 0, 0, 3, 2, 3, 0, 1);
        cyc("post_rst_r0_r1", 0, 0, 0, 0, 0, 0, 3, 0, 3, 1);
        cyc("post_rst_r2_r3", 0, 0, 0, 0, 0, 0, 3, 2, 3, 3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
